// File: rtl/disparity_median_filter_pkg.sv
// Shared types and constants for the disparity median post-filter.
package disp_filter_pkg;

  localparam int IMG_W_DEF = 640;
  localparam int IMG_H_DEF = 480;
  localparam int DW_DEF    = 8;
  // Fixed output latency: window register, sorter partial stage, output register.
  localparam int PIPE_LAT  = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    RUN   = 2'd2,
    FLUSH = 2'd3
  } filt_state_e;

  // Width of a counter that indexes every pixel of a w x h frame.
  function automatic int pix_cnt_w(input int w, input int h);
    return $clog2(w * h);
  endfunction

endpackage

// File: rtl/disparity_median_filter_median9.sv
// Two-stage 9-input median sorter. Rows are sorted, then the median is the
// median of (max of row minima, median of row medians, min of row maxima).
// The partial results are registered (gated by i_valid only); the final
// three-input median is combinational and is registered by the caller.
module median9 #(
  parameter int DW = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_clr,
  input  logic                 i_valid,
  input  logic [8:0][DW-1:0]   i_win,
  output logic                 o_valid,
  output logic [DW-1:0]        o_med
);

  function automatic logic [DW-1:0] mn2(input logic [DW-1:0] a, input logic [DW-1:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [DW-1:0] mx2(input logic [DW-1:0] a, input logic [DW-1:0] b);
    return (a < b) ? b : a;
  endfunction

  function automatic logic [DW-1:0] md3(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                        input logic [DW-1:0] c);
    return mx2(mn2(a, b), mn2(mx2(a, b), c));
  endfunction

  logic [2:0][DW-1:0] lo, mid, hi;
  logic [DW-1:0]      lo_max, mid_med, hi_min;
  logic [DW-1:0]      lo_q, mid_q, hi_q;
  logic               v_q;

  // Sort each row of three, then reduce the three sorted columns.
  always_comb begin
    lo      = '0;
    mid     = '0;
    hi      = '0;
    for (int r = 0; r < 3; r++) begin
      lo[r]  = mn2(mn2(i_win[3*r], i_win[3*r+1]), i_win[3*r+2]);
      hi[r]  = mx2(mx2(i_win[3*r], i_win[3*r+1]), i_win[3*r+2]);
      mid[r] = md3(i_win[3*r], i_win[3*r+1], i_win[3*r+2]);
    end
    lo_max  = mx2(mx2(lo[0], lo[1]), lo[2]);
    mid_med = md3(mid[0], mid[1], mid[2]);
    hi_min  = mn2(mn2(hi[0], hi[1]), hi[2]);
  end

  // Partial-result register, loaded only when a real window is presented.
  always_ff @(posedge i_clk) begin
    if (i_valid) begin
      lo_q  <= lo_max;
      mid_q <= mid_med;
      hi_q  <= hi_min;
    end
  end

  // Valid bit for the partial stage; i_clr drops in-flight results.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) v_q <= 1'b0;
    else          v_q <= i_valid && !i_clr;
  end

  assign o_valid = v_q;
  assign o_med   = md3(lo_q, mid_q, hi_q);

endmodule

// File: rtl/disparity_median_filter.sv
// Streaming 3x3 median post-filter for the raster-order disparity stream.
// Interior pixels become the median of their 3x3 neighbourhood; border
// pixels pass through. Input is a strobe (i_valid) with no backpressure:
// a pixel is taken on every cycle i_valid is high except during FLUSH,
// and o_valid is a one-cycle strobe per output pixel.
module disparity_median_filter
  import disp_filter_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF,
  parameter int DW    = DW_DEF
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_start,
  input  logic          i_valid,
  input  logic [DW-1:0] i_data,
  output logic          o_valid,
  output logic [DW-1:0] o_data,
  output logic          o_frame_done,
  output logic          o_overrun,
  output filt_state_e   o_state
);

  localparam int N   = IMG_W * IMG_H;
  localparam int PCW = pix_cnt_w(IMG_W, IMG_H);
  localparam int CW  = $clog2(IMG_W);
  localparam int YW  = $clog2(IMG_H);
  localparam int FW  = $clog2(IMG_W + 1);

  filt_state_e    state_q, state_d;
  logic [PCW-1:0] in_cnt_q;
  logic [CW-1:0]  col_q, col_eff;
  logic [FW-1:0]  fl_cnt_q;
  logic [CW-1:0]  x_q;
  logic [YW-1:0]  y_q;
  logic           ovr_q;

  logic           accept, pseudo, adv, launch;
  logic           last_in, fl_last, bord, fdone;
  logic [DW-1:0]  pix, rd0, rd1;

  logic [DW-1:0]  lb0 [IMG_W];
  logic [DW-1:0]  lb1 [IMG_W];
  logic [DW-1:0]  win [3][3];
  logic [8:0][DW-1:0] win_flat;

  logic           v1, b1, d1;
  logic           b2, d2;
  logic [DW-1:0]  c2;
  logic           m_valid;
  logic [DW-1:0]  m_med;

  assign last_in = (in_cnt_q == PCW'(N - 1));
  assign fl_last = (fl_cnt_q == FW'(IMG_W));

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic; i_start overrides everything, including a last pixel.
  always_comb begin
    state_d = state_q;
    if (i_start) begin
      state_d = i_valid ? FILL : IDLE;
    end else begin
      case (state_q)
        IDLE:    if (i_valid) state_d = FILL;
        FILL:    if (i_valid && in_cnt_q == PCW'(IMG_W)) state_d = RUN;
        RUN:     if (i_valid && last_in) state_d = FLUSH;
        FLUSH:   if (fl_last) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Per-cycle strobes derived from state: accepted pixel, pseudo pixel, output launch.
  always_comb begin
    accept  = i_valid && ((state_q != FLUSH) || i_start);
    pseudo  = (state_q == FLUSH) && !i_start;
    adv     = accept || pseudo;
    launch  = !i_start && (((state_q == RUN) && i_valid) || pseudo);
    pix     = pseudo ? '0 : i_data;
    // A pixel arriving with i_start is column 0 of the new frame.
    col_eff = i_start ? '0 : col_q;
    bord    = (x_q == '0) || (x_q == CW'(IMG_W - 1)) ||
              (y_q == '0) || (y_q == YW'(IMG_H - 1));
    fdone   = (x_q == CW'(IMG_W - 1)) && (y_q == YW'(IMG_H - 1));
  end

  assign o_state = state_q;

  // Input, flush and output-position counters plus the sticky overrun flag.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      in_cnt_q <= '0;
      col_q    <= '0;
      fl_cnt_q <= '0;
      x_q      <= '0;
      y_q      <= '0;
      ovr_q    <= 1'b0;
    end else if (i_start) begin
      in_cnt_q <= PCW'(i_valid);
      col_q    <= CW'(i_valid);
      fl_cnt_q <= '0;
      x_q      <= '0;
      y_q      <= '0;
      ovr_q    <= 1'b0;
    end else begin
      if (accept) in_cnt_q <= last_in ? '0 : in_cnt_q + 1'b1;
      if (adv)    col_q    <= (col_q == CW'(IMG_W - 1)) ? '0 : col_q + 1'b1;
      if (pseudo) begin
        if (fl_last) begin
          fl_cnt_q <= '0;
          col_q    <= '0;
        end else begin
          fl_cnt_q <= fl_cnt_q + 1'b1;
        end
      end
      if (launch) begin
        if (x_q == CW'(IMG_W - 1)) begin
          x_q <= '0;
          y_q <= (y_q == YW'(IMG_H - 1)) ? '0 : y_q + 1'b1;
        end else begin
          x_q <= x_q + 1'b1;
        end
      end
      if ((state_q == FLUSH) && i_valid) ovr_q <= 1'b1;
    end
  end

  assign o_overrun = ovr_q;

  // Read-before-write line buffers sharing one column pointer.
  assign rd0 = lb0[col_eff];
  assign rd1 = lb1[col_eff];

  // Line buffers: lb0 holds the previous row, lb1 the row before it.
  always_ff @(posedge i_clk) begin
    if (adv) begin
      lb0[col_eff] <= pix;
      lb1[col_eff] <= rd0;
    end
  end

  // 3x3 window (stage 1): shift left, newest column enters at index 2.
  always_ff @(posedge i_clk) begin
    if (adv) begin
      for (int r = 0; r < 3; r++) begin
        win[r][0] <= win[r][1];
        win[r][1] <= win[r][2];
      end
      win[0][2] <= rd1;
      win[1][2] <= rd0;
      win[2][2] <= pix;
    end
  end

  assign win_flat = {win[0][0], win[0][1], win[0][2],
                     win[1][0], win[1][1], win[1][2],
                     win[2][0], win[2][1], win[2][2]};

  // Stage-1 sideband: valid, border flag and end-of-frame flag for the window.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      v1 <= 1'b0;
      b1 <= 1'b0;
      d1 <= 1'b0;
    end else begin
      v1 <= launch;
      if (launch) begin
        b1 <= bord;
        d1 <= fdone;
      end
    end
  end

  // Stage-2 sideband travels beside the sorter's partial register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      b2 <= 1'b0;
      d2 <= 1'b0;
      c2 <= '0;
    end else if (v1) begin
      b2 <= b1;
      d2 <= d1;
      c2 <= win[1][1];
    end
  end

  median9 #(.DW(DW)) u_median9 (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (i_start),
    .i_valid (v1),
    .i_win   (win_flat),
    .o_valid (m_valid),
    .o_med   (m_med)
  );

  // Stage-3 output register: border pixels take the centre, others the median.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid      <= 1'b0;
      o_data       <= '0;
      o_frame_done <= 1'b0;
    end else begin
      o_valid      <= m_valid && !i_start;
      o_frame_done <= m_valid && d2 && !i_start;
      if (m_valid && !i_start) o_data <= b2 ? c2 : m_med;
    end
  end

endmodule

// File: tb/tb_disparity_median_filter.sv
// Directed bench for disparity_median_filter on an 8x6 frame.
module tb_disparity_median_filter;
  import disp_filter_pkg::*;

  localparam int W = 8;
  localparam int H = 6;
  localparam int N = W * H;

  logic        i_clk   = 1'b0;
  logic        i_rst_n = 1'b1;
  logic        i_start = 1'b0;
  logic        i_valid = 1'b0;
  logic [7:0]  i_data  = 8'h00;
  logic        o_valid;
  logic [7:0]  o_data;
  logic        o_frame_done;
  logic        o_overrun;
  filt_state_e o_state;

  disparity_median_filter #(.IMG_W(W), .IMG_H(H), .DW(8)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_start      (i_start),
    .i_valid      (i_valid),
    .i_data       (i_data),
    .o_valid      (o_valid),
    .o_data       (o_data),
    .o_frame_done (o_frame_done),
    .o_overrun    (o_overrun),
    .o_state      (o_state)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int         errors = 0;
  int         checks = 0;
  int         out_cnt, done_cnt, done_idx;
  logic [7:0] out_q [64];
  int         out_cyc [64];
  logic [7:0] exp_q [$];
  int         acc_cyc, acc9, acc_last;
  logic [7:0] d;

  // Output monitor, sampling on the falling edge.
  always @(negedge i_clk) begin
    if (o_valid) begin
      if (out_cnt < 64) begin
        out_q[out_cnt]   = o_data;
        out_cyc[out_cnt] = cyc;
      end
      out_cnt = out_cnt + 1;
    end
    if (o_frame_done) begin
      done_cnt = done_cnt + 1;
      done_idx = out_cnt - 1;
    end
  end

  // ---------------- driver / checker tasks ----------------
  task automatic chk(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic send(input logic [7:0] dv, input int gap);
    acc_cyc = cyc;
    i_valid = 1'b1;
    i_data  = dv;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    repeat (gap) begin @(posedge i_clk); #1; end
  endtask

  task automatic clear_mon();
    out_cnt  = 0;
    done_cnt = 0;
    done_idx = -1;
    for (int i = 0; i < 64; i++) begin
      out_q[i]   = 8'hEE;
      out_cyc[i] = 0;
    end
  endtask

  // Bounded wait for frame_done, then a few cycles to catch stray outputs.
  task automatic wait_done();
    for (int i = 0; i < 80 && done_cnt == 0; i++) begin
      @(posedge i_clk); #1;
    end
    repeat (6) begin @(posedge i_clk); #1; end
  endtask

  task automatic check_frame(input string tag);
    logic [7:0] e;
    chk($sformatf("%s_count", tag), out_cnt, N);
    chk($sformatf("%s_done_cnt", tag), done_cnt, 1);
    chk($sformatf("%s_done_idx", tag), done_idx, N - 1);
    for (int i = 0; i < N; i++) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hEE;
      chk($sformatf("%s_px%0d", tag, i), int'(out_q[i]), int'(e));
    end
    exp_q.delete();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    #2 i_rst_n = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_valid", o_valid, 0);
    chk("rst_data", o_data, 0);
    chk("rst_done", o_frame_done, 0);
    chk("rst_overrun", o_overrun, 0);
    chk("rst_state", int'(o_state), int'(IDLE));
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;

    // Frame A: constant 0x20, continuous, starting from IDLE.
    clear_mon();
    for (int k = 0; k < N; k++) begin
      send(8'h20, 0);
      if (k == W + 1) acc9 = acc_cyc;
    end
    for (int k = 0; k < N; k++) exp_q.push_back(8'h20);
    wait_done();
    check_frame("const20");
    chk("first_latency", out_cyc[0], acc9 + 3);

    // Frame B: ramp x+8y with spikes, one pixel every third cycle.
    clear_mon();
    for (int k = 0; k < N; k++) begin
      d = 8'(k);
      if (k == 19 || k == 40) d = 8'hFF;
      if (k == 29) d = 8'h00;
      send(d, 2);
      if (k == N - 1) acc_last = acc_cyc;
    end
    for (int k = 0; k < N; k++) begin
      case (k)
        19, 20, 21: d = 8'd20;
        22:         d = 8'd21;
        26:         d = 8'd27;
        27, 29:     d = 8'd28;
        40:         d = 8'hFF;
        default:    d = 8'(k);
      endcase
      exp_q.push_back(d);
    end
    wait_done();
    check_frame("spike");
    chk("flush_span", out_cyc[N-1] - out_cyc[N-9], 8);
    chk("last_latency", out_cyc[N-1], acc_last + 12);

    // Frame C: abort a 0x55 frame at pixel 20 with i_start carrying pixel 0 of 0x07.
    for (int k = 0; k < 20; k++) send(8'h55, 0);
    i_start = 1'b1;
    i_valid = 1'b1;
    i_data  = 8'h07;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    i_valid = 1'b0;
    clear_mon();
    chk("start_drop_valid", o_valid, 0);
    for (int k = 1; k < N; k++) send(8'h07, 0);
    chk("flush_state", int'(o_state), int'(FLUSH));
    chk("overrun_before", o_overrun, 0);
    i_valid = 1'b1;
    i_data  = 8'hAA;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    chk("overrun_set", o_overrun, 1);
    for (int k = 0; k < N; k++) exp_q.push_back(8'h07);
    wait_done();
    check_frame("restart07");
    chk("overrun_sticky", o_overrun, 1);
    i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    chk("overrun_clr", o_overrun, 0);
    chk("start_idle", int'(o_state), int'(IDLE));

    // Frame D: reset asserted in the middle of FLUSH.
    clear_mon();
    for (int k = 0; k < N; k++) send(8'h33, 0);
    repeat (4) begin @(posedge i_clk); #1; end
    chk("mid_flush_state", int'(o_state), int'(FLUSH));
    i_rst_n = 1'b0;
    #1;
    chk("arst_valid", o_valid, 0);
    chk("arst_data", o_data, 0);
    chk("arst_done", o_frame_done, 0);
    chk("arst_state", int'(o_state), int'(IDLE));
    @(posedge i_clk); #1;
    chk("arst_edge_valid", o_valid, 0);
    chk("arst_no_done", done_cnt, 0);
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;

    // Frame E: clean frame after the reset.
    clear_mon();
    for (int k = 0; k < N; k++) send(8'h44, 0);
    for (int k = 0; k < N; k++) exp_q.push_back(8'h44);
    wait_done();
    check_frame("post_reset44");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
